// File: rtl/conv_pkg.sv
// Shared geometry and state encoding for the conv result path.
package conv_pkg;
  localparam int OUT_H = 6;
  localparam int OUT_W = 6;
  localparam int OUT_C = 3;
  localparam int DW    = 8;
  localparam int N     = OUT_H * OUT_W * OUT_C;
  localparam int IDX_W = $clog2(N);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;
endpackage

// File: rtl/rise_det.sv
// Rising-edge detector: one history flop plus an AND. A level already high at reset
// release counts as a rise because the history flop resets low.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
endmodule

// File: rtl/conv_result_streamer.sv
// Captures one conv_module result frame on each conv_vld rise and streams it out
// byte by byte on a valid/ready port, index 0 first.
module conv_result_streamer
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 conv_vld,
  input  logic [N*DW-1:0]      conv_lin,
  output logic [DW-1:0]        m_data,
  output logic [IDX_W-1:0]     m_idx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 ovf_err
);
  state_e                  r_state;
  logic [N-1:0][DW-1:0]    r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_ovf;
  logic                    w_rise;
  logic                    w_fire;
  logic                    w_is_last;

  rise_det u_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (conv_vld),
    .o_rise (w_rise)
  );

  assign w_is_last = (r_idx == IDX_W'(N-1));
  assign w_fire    = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_shadow <= conv_lin;
            r_idx    <= '0;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_fire && w_is_last) begin
            // A rise landing on the final handshake chains the next frame with no bubble.
            if (w_rise) begin
              r_shadow <= conv_lin;
              r_idx    <= '0;
            end else begin
              r_state  <= ST_IDLE;
            end
          end else begin
            if (w_fire) r_idx <= r_idx + 1'b1;
            if (w_rise) r_ovf <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come straight from registered state/idx, so m_ready never reaches m_valid.
  assign m_valid = (r_state == ST_SEND);
  assign busy    = (r_state == ST_SEND);
  assign m_last  = m_valid & w_is_last;
  assign m_data  = r_shadow[r_idx];
  assign m_idx   = r_idx;
  assign ovf_err = r_ovf;
endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: single frame, backpressure, level input,
// overflow, reset mid-stream and back-to-back frames.
module tb_conv_result_streamer;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              conv_vld;
  logic [N*DW-1:0]   conv_lin;
  logic [DW-1:0]     m_data;
  logic [IDX_W-1:0]  m_idx;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              ovf_err;

  int n_cmp = 0;
  int n_err = 0;

  conv_result_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .conv_vld (conv_vld),
    .conv_lin (conv_lin),
    .m_data   (m_data),
    .m_idx    (m_idx),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bval(input int k, input int i);
    int v;
    case (k)
      0:       v = i;
      1:       v = 255;
      default: v = i * 37 + 128;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [N*DW-1:0] frame(input int k);
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = bval(k, i);
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; conv_vld = 1'b0; conv_lin = frame(0); m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 ||
        m_idx !== '0 || m_data !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%b last=%b busy=%b ovf=%b idx=%0d data=%h, want all 0",
               m_valid, m_last, busy, ovf_err, m_idx, m_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_single();
    int exp = 0, cyc = 0;
    conv_lin = frame(0); conv_vld = 1'b1; m_ready = 1'b1;
    while (exp < N && cyc < 300) begin
      @(negedge clk); cyc++;
      if (m_valid) begin
        n_cmp++;
        if (m_data !== bval(0, exp) || m_idx !== exp[6:0] || m_last !== (exp == N-1) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_beat%0d: data=%h idx=%0d last=%b busy=%b want data=%h idx=%0d",
                   exp, m_data, m_idx, m_last, busy, bval(0, exp), exp);
        end
        exp++;
      end
    end
    n_cmp++;
    if (exp != N || cyc != N) begin
      n_err++; $display("FAIL single_timing: beats=%0d cycles=%0d want %0d/%0d", exp, cyc, N, N);
    end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
      n_err++; $display("FAIL single_end: valid=%b busy=%b last=%b want 0", m_valid, busy, m_last);
    end
    conv_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int exp = 0, cyc = 0, stalls = 0;
    logic [3:0] pat = 4'b1001;
    conv_lin = frame(2); conv_vld = 1'b1;
    while (exp < N && cyc < 1000) begin
      @(negedge clk); cyc++;
      m_ready = pat[cyc % 4] ^ ($urandom_range(0, 7) == 0);
      if (m_valid) begin
        n_cmp++;
        if (m_data !== bval(2, exp) || m_idx !== exp[6:0] || m_last !== (exp == N-1)) begin
          n_err++;
          $display("FAIL bp_beat%0d: data=%h idx=%0d last=%b want data=%h idx=%0d",
                   exp, m_data, m_idx, m_last, bval(2, exp), exp);
        end
        if (m_ready) exp++;
        else stalls++;
      end
    end
    n_cmp++;
    if (exp != N || stalls == 0) begin
      n_err++; $display("FAIL bp_count: beats=%0d stalls=%0d want %0d beats and some stalls", exp, stalls, N);
    end
    m_ready = 1'b1;
    conv_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_extra: valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_level();
    int beats = 0, bad = 0;
    conv_lin = frame(0); conv_vld = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (m_valid) begin
        if (beats >= N || m_data !== bval(0, beats) || m_idx !== beats[6:0]) bad++;
        beats++;
      end
    end
    n_cmp++;
    if (beats != N || bad != 0 || ovf_err !== 1'b0) begin
      n_err++; $display("FAIL level: beats=%0d bad=%0d ovf=%b want %0d/0/0", beats, bad, ovf_err, N);
    end
    conv_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int exp = 0, cyc = 0;
    conv_lin = frame(0); conv_vld = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    conv_vld = 1'b0;
    while (exp < N && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (exp == 50) begin conv_vld = 1'b1; conv_lin = frame(1); end
      if (m_valid) begin
        n_cmp++;
        if (m_data !== bval(0, exp) || m_idx !== exp[6:0]) begin
          n_err++;
          $display("FAIL ovf_beat%0d: data=%h idx=%0d want data=%h", exp, m_data, m_idx, bval(0, exp));
        end
        exp++;
      end
    end
    n_cmp++;
    if (exp != N) begin
      n_err++; $display("FAIL ovf_count: beats=%0d want %0d", exp, N);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0 || c == 19) begin
        n_cmp++;
        if (ovf_err !== 1'b1 || m_valid !== 1'b0) begin
          n_err++; $display("FAIL ovf_sticky%0d: ovf=%b valid=%b want 1/0", c, ovf_err, m_valid);
        end
      end
    end
    conv_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int exp = 0, cyc = 0;
    conv_lin = frame(2); conv_vld = 1'b1; m_ready = 1'b1;
    while (exp < 30 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (m_valid) exp++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 ||
        m_idx !== '0 || m_data !== '0) begin
      n_err++;
      $display("FAIL rstmid: valid=%b last=%b busy=%b ovf=%b idx=%0d data=%h want all 0",
               m_valid, m_last, busy, ovf_err, m_idx, m_data);
    end
    conv_lin = frame(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp = 0; cyc = 0;
    while (exp < N && cyc < 300) begin
      @(negedge clk); cyc++;
      if (m_valid) begin
        n_cmp++;
        if (m_data !== bval(0, exp) || m_idx !== exp[6:0]) begin
          n_err++;
          $display("FAIL rstmid_beat%0d: data=%h idx=%0d want data=%h", exp, m_data, m_idx, bval(0, exp));
        end
        exp++;
      end
    end
    n_cmp++;
    if (exp != N || cyc != N) begin
      n_err++; $display("FAIL rstmid_count: beats=%0d cycles=%0d want %0d/%0d", exp, cyc, N, N);
    end
    conv_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int exp = 0, cyc = 0, k = 0;
    conv_lin = frame(0); conv_vld = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    conv_vld = 1'b0;
    while (cyc < 400 && !(k == 1 && exp == N)) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (m_valid) begin
        n_cmp++;
        if (m_data !== bval(k, exp) || m_idx !== exp[6:0] || m_last !== (exp == N-1) || ovf_err !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_f%0d_beat%0d: data=%h idx=%0d last=%b ovf=%b want data=%h idx=%0d ovf=0",
                   k, exp, m_data, m_idx, m_last, ovf_err, bval(k, exp), exp);
        end
        if (k == 0 && exp == N-1) begin
          conv_vld = 1'b1; conv_lin = frame(1);
          k = 1; exp = 0;
        end else begin
          if (k == 1) conv_vld = 1'b0;
          exp++;
        end
      end else if (k == 1) begin
        n_err++; n_cmp++;
        $display("FAIL b2b_bubble: valid=%b at frame B beat %0d want 1", m_valid, exp);
      end
    end
    n_cmp++;
    if (k != 1 || exp != N) begin
      n_err++; $display("FAIL b2b_count: frame=%0d beats=%0d want 1/%0d", k, exp, N);
    end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || ovf_err !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: valid=%b ovf=%b want 0/0", m_valid, ovf_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_level();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
